// File: rtl/uart_frame_decoder_pkg.sv
// Shared types and constants for the multi-channel UART frame decoder.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_CHAN = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_CHAN    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte-strobe input and frame-result output bundle of the frame decoder.
interface uart_frame_decoder_if #(
  parameter int PAYLOAD_BYTES = 11,
  parameter int CH_NUM        = 4
);

  logic [7:0]                 data_i;
  logic                       rx_done_tick_i;
  logic [8*PAYLOAD_BYTES-1:0] payload_o;
  logic [3:0]                 channel_o;
  logic [CH_NUM-1:0]          ch_load_o;
  logic                       done_tick_o;
  logic                       err_tick_o;
  logic [1:0]                 err_code_o;

  modport master (
    output data_i,
    output rx_done_tick_i,
    input  payload_o,
    input  channel_o,
    input  ch_load_o,
    input  done_tick_o,
    input  err_tick_o,
    input  err_code_o
  );

  modport slave (
    input  data_i,
    input  rx_done_tick_i,
    output payload_o,
    output channel_o,
    output ch_load_o,
    output done_tick_o,
    output err_tick_o,
    output err_code_o
  );

endinterface

// File: rtl/uart_frame_decoder_timeout.sv
// Inter-byte idle watchdog: flags expiry after TIMEOUT_CYC quiet cycles while enabled.
module frame_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int            CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] idle_cnt_r;

  // A byte strobe in the expiry cycle suppresses expiry so the byte is kept.
  assign expire_o = en_i && !clr_i && (idle_cnt_r == CNT_LAST);

  // Idle cycle counter, held at zero while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_r <= '0;
    end else if (!en_i || clr_i || expire_o) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame assembler: sync, channel, payload, checksum; routes good frames to one of CH_NUM channels.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 11,
  parameter int         CH_NUM        = 4,
  parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC   = 50000
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  uart_frame_decoder_if.slave bus
);

  localparam int                PW       = 8 * PAYLOAD_BYTES;
  localparam int                CNT_W    = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [7:0]        CH_LIMIT = 8'(CH_NUM);
  localparam logic [CH_NUM-1:0] CH_ONE   = CH_NUM'(1);

  state_t            state_r;
  logic [7:0]        chan_r;
  logic [7:0]        sum_r;
  logic [CNT_W-1:0]  byte_cnt_r;
  logic [PW-1:0]     buf_r;
  logic [PW-1:0]     payload_r;
  logic [3:0]        channel_r;
  logic [CH_NUM-1:0] ch_load_r;
  logic              done_r;
  logic              err_r;
  logic [1:0]        err_code_r;
  logic              tick_s;
  logic              to_en_s;
  logic              expire_s;

  // New bytes enter at the top so the first payload byte ends up in [7:0].
  function automatic logic [PW-1:0] shift_in(input logic [PW-1:0] cur, input logic [7:0] b);
    logic [PW-1:0] res;
    res            = cur >> 8;
    res[PW-1 -: 8] = b;
    return res;
  endfunction

  assign tick_s  = bus.rx_done_tick_i;
  assign to_en_s = (state_r != S_HUNT);

  frame_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (to_en_s),
    .clr_i    (tick_s),
    .expire_o (expire_s)
  );

  // Frame FSM with registered result outputs and one-cycle pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= S_HUNT;
      chan_r     <= 8'd0;
      sum_r      <= 8'd0;
      byte_cnt_r <= '0;
      buf_r      <= '0;
      payload_r  <= '0;
      channel_r  <= 4'd0;
      ch_load_r  <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      ch_load_r <= '0;
      if (expire_s) begin
        err_r      <= 1'b1;
        err_code_r <= ERR_TIMEOUT;
        state_r    <= S_HUNT;
      end else if (tick_s) begin
        case (state_r)
          S_HUNT: begin
            if (bus.data_i == SYNC_BYTE) begin
              state_r <= S_CHAN;
            end else begin
              state_r <= S_HUNT;
            end
          end
          S_CHAN: begin
            chan_r     <= bus.data_i;
            sum_r      <= bus.data_i;
            byte_cnt_r <= '0;
            state_r    <= S_DATA;
          end
          S_DATA: begin
            buf_r      <= shift_in(buf_r, bus.data_i);
            sum_r      <= sum_r + bus.data_i;
            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
            if (byte_cnt_r == LAST_IDX) begin
              state_r <= S_CSUM;
            end else begin
              state_r <= S_DATA;
            end
          end
          S_CSUM: begin
            // Checksum errors outrank an out-of-range channel.
            if (bus.data_i != sum_r) begin
              err_r      <= 1'b1;
              err_code_r <= ERR_CSUM;
            end else if (chan_r >= CH_LIMIT) begin
              err_r      <= 1'b1;
              err_code_r <= ERR_CHAN;
            end else begin
              payload_r <= buf_r;
              channel_r <= chan_r[3:0];
              ch_load_r <= CH_ONE << chan_r[3:0];
              done_r    <= 1'b1;
            end
            state_r <= S_HUNT;
          end
          default: begin
            state_r <= S_HUNT;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.payload_o   = payload_r;
  assign bus.channel_o   = channel_r;
  assign bus.ch_load_o   = ch_load_r;
  assign bus.done_tick_o = done_r;
  assign bus.err_tick_o  = err_r;
  assign bus.err_code_o  = err_code_r;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed self-checking bench for uart_frame_decoder (11-byte payload, 4 channels, 16-cycle timeout).
module tb_uart_frame_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   n;

  localparam logic [87:0] PL_SEQ  = 88'h0B0A09080706050403020_1;
  localparam logic [87:0] PL_ALT  = 88'h1A191817161514131211_10;
  localparam logic [87:0] PL_55   = {11{8'h55}};

  always #5 clk = ~clk;

  uart_frame_decoder_if #(.PAYLOAD_BYTES(11), .CH_NUM(4)) bus ();

  uart_frame_decoder #(
    .PAYLOAD_BYTES(11),
    .CH_NUM       (4),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one byte with the strobe high for exactly one clock edge; strobe stays high.
  task automatic tick_byte(input logic [7:0] b);
    bus.data_i         = b;
    bus.rx_done_tick_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rx_done_tick_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] ch, input logic [87:0] pl, input logic [7:0] cs);
    tick_byte(8'hA5);
    tick_byte(ch);
    for (int i = 0; i < 11; i++) tick_byte(pl[i*8 +: 8]);
    tick_byte(cs);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.data_i         = 8'h00;
    bus.rx_done_tick_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_payload", bus.payload_o, 88'h0);
    check("rst_channel", bus.channel_o, 4'd0);
    check("rst_ch_load", bus.ch_load_o, 4'b0000);
    check("rst_done", bus.done_tick_o, 1'b0);
    check("rst_err", bus.err_tick_o, 1'b0);
    check("rst_err_code", bus.err_code_o, 2'd0);
    rst_n = 1'b1;
    idle();

    // Good frame on channel 2.
    send_frame(8'h02, PL_SEQ, 8'h44);
    check("good_done", bus.done_tick_o, 1'b1);
    check("good_ch_load", bus.ch_load_o, 4'b0100);
    check("good_channel", bus.channel_o, 4'd2);
    check("good_payload", bus.payload_o, PL_SEQ);
    check("good_no_err", bus.err_tick_o, 1'b0);
    idle();
    check("good_done_drop", bus.done_tick_o, 1'b0);
    check("good_ch_load_drop", bus.ch_load_o, 4'b0000);

    // Wrong checksum.
    send_frame(8'h02, PL_ALT, 8'h45);
    check("csum_err", bus.err_tick_o, 1'b1);
    check("csum_code", bus.err_code_o, 2'd1);
    check("csum_no_done", bus.done_tick_o, 1'b0);
    check("csum_payload_kept", bus.payload_o, PL_SEQ);
    idle();
    check("csum_err_drop", bus.err_tick_o, 1'b0);
    check("csum_code_held", bus.err_code_o, 2'd1);

    // Out-of-range channel with a correct checksum.
    send_frame(8'h07, PL_SEQ, 8'h49);
    check("chan_err", bus.err_tick_o, 1'b1);
    check("chan_code", bus.err_code_o, 2'd2);
    check("chan_no_load", bus.ch_load_o, 4'b0000);
    check("chan_no_done", bus.done_tick_o, 1'b0);
    check("chan_channel_kept", bus.channel_o, 4'd2);
    idle();

    // Garbage before a good frame is skipped silently.
    tick_byte(8'h00);
    tick_byte(8'hFF);
    tick_byte(8'h5A);
    check("garbage_no_err", bus.err_tick_o, 1'b0);
    send_frame(8'h02, PL_SEQ, 8'h44);
    check("garbage_done", bus.done_tick_o, 1'b1);
    check("garbage_err", bus.err_tick_o, 1'b0);
    check("garbage_payload", bus.payload_o, PL_SEQ);
    idle();

    // Truncated frame times out 16 cycles after the last byte.
    tick_byte(8'hA5);
    tick_byte(8'h02);
    for (int i = 1; i <= 5; i++) tick_byte(8'(i));
    bus.rx_done_tick_i = 1'b0;
    n = 0;
    while (!bus.err_tick_o && n < 40) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check("timeout_latency", n, 16);
    check("timeout_err", bus.err_tick_o, 1'b1);
    check("timeout_code", bus.err_code_o, 2'd3);
    check("timeout_payload_kept", bus.payload_o, PL_SEQ);
    idle();
    send_frame(8'h01, PL_ALT, 8'hE8);
    check("after_to_done", bus.done_tick_o, 1'b1);
    check("after_to_ch_load", bus.ch_load_o, 4'b0010);
    check("after_to_channel", bus.channel_o, 4'd1);
    check("after_to_payload", bus.payload_o, PL_ALT);
    idle();

    // Back-to-back frames: sync strobe directly follows the checksum strobe.
    send_frame(8'h02, PL_SEQ, 8'h44);
    check("b2b_first_done", bus.done_tick_o, 1'b1);
    check("b2b_first_payload", bus.payload_o, PL_SEQ);
    send_frame(8'h00, PL_55, 8'hA7);
    check("b2b_second_done", bus.done_tick_o, 1'b1);
    check("b2b_second_ch_load", bus.ch_load_o, 4'b0001);
    check("b2b_second_channel", bus.channel_o, 4'd0);
    check("b2b_second_payload", bus.payload_o, PL_55);
    idle();

    // Reset mid-frame discards the partial frame and clears outputs.
    tick_byte(8'hA5);
    tick_byte(8'h02);
    for (int i = 0; i < 11; i++) tick_byte(PL_SEQ[i*8 +: 8]);
    bus.rx_done_tick_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick_byte(8'h44);
    check("midrst_no_done", bus.done_tick_o, 1'b0);
    check("midrst_no_err", bus.err_tick_o, 1'b0);
    check("midrst_payload", bus.payload_o, 88'h0);
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
